// File: rtl/gpc_mc.sv
// gpc_mc -- multi-cycle RV32I-subset core (LUI, AUIPC, JAL, JALR, BRANCH,
// OP-IMM, OP, EBREAK). Every instruction goes through FETCH -> WAIT -> EXEC,
// so it takes at least three cycles. Illegal or misaligned instructions and
// EBREAK stop the core in HALT until the next reset.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   ifu_req_valid   : fetch request (high in FETCH only)
//   ifu_req_ready   : fetch request accepted
//   ifu_addr        : fetch address (= pc, held while the request is pending)
//   ifu_rsp_valid   : instruction word valid (taken into account in WAIT only)
//   ifu_rsp_inst    : instruction word
//   pc              : current program counter
//   commit          : one-cycle pulse in the cycle after a retiring EXEC
//   halt            : core stopped
//   illegal         : halt was caused by an illegal or misaligned instruction
//
// Configuration macro GPC_MC_RVE_EN: when defined, the register file has 16
// entries and any rd/rs1/rs2 field the instruction uses with bit 4 set is
// treated as illegal.
module gpc_mc #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] PC_START   = WIDTH'(32'h8000_0000),
    parameter int               NR_REGS    = 32,
    parameter int               ADDR_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [WIDTH-1:0] ifu_addr,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rsp_inst,
    output logic [WIDTH-1:0] pc,
    output logic             commit,
    output logic             halt,
    output logic             illegal
);

`ifdef GPC_MC_RVE_EN
    localparam int RF_N   = 16;
    localparam int RF_AW  = 4;
    localparam bit RVE_EN = 1'b1;
`else
    localparam int RF_N   = NR_REGS;
    localparam int RF_AW  = ADDR_WIDTH;
    localparam bit RVE_EN = 1'b0;
`endif

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t           state_r;
    logic [31:0]      inst_r;
    logic [WIDTH-1:0] pc_r;
    logic             req_valid_r;
    logic             commit_r;
    logic             halt_r;
    logic             illegal_r;
    logic [WIDTH-1:0] rf_r [RF_N];

    // Integer ALU shared by OP and OP-IMM; alt selects SUB / SRA.
    function automatic logic [WIDTH-1:0] alu(input logic [2:0] f3, input logic alt,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[SHW-1:0];
            3'b010:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011:  r = {{(WIDTH-1){1'b0}}, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? $unsigned($signed(a) >>> b[SHW-1:0]) : (a >> b[SHW-1:0]);
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [6:0]       opcode_s;
    logic [2:0]       f3_s;
    logic [6:0]       f7_s;
    logic [4:0]       rd_s, rs1_idx_s, rs2_idx_s;
    logic [WIDTH-1:0] rs1_val_s, rs2_val_s;
    logic [WIDTH-1:0] imm_i_s, imm_u_s, imm_b_s, imm_j_s;
    logic [WIDTH-1:0] pc4_s, jalr_sum_s;

    assign opcode_s  = inst_r[6:0];
    assign f3_s      = inst_r[14:12];
    assign f7_s      = inst_r[31:25];
    assign rd_s      = inst_r[11:7];
    assign rs1_idx_s = inst_r[19:15];
    assign rs2_idx_s = inst_r[24:20];
    assign rs1_val_s = (rs1_idx_s == 5'd0) ? '0 : rf_r[rs1_idx_s[RF_AW-1:0]];
    assign rs2_val_s = (rs2_idx_s == 5'd0) ? '0 : rf_r[rs2_idx_s[RF_AW-1:0]];

    assign imm_i_s = {{(WIDTH-12){inst_r[31]}}, inst_r[31:20]};
    assign imm_u_s = {{(WIDTH-20){inst_r[31]}}, inst_r[31:12]} << 12;
    assign imm_b_s = {{(WIDTH-12){inst_r[31]}}, inst_r[7], inst_r[30:25], inst_r[11:8], 1'b0};
    assign imm_j_s = {{(WIDTH-20){inst_r[31]}}, inst_r[19:12], inst_r[20], inst_r[30:21], 1'b0};
    assign pc4_s      = pc_r + WIDTH'(3'd4);
    assign jalr_sum_s = rs1_val_s + imm_i_s;

    logic             ill_s, brk_s, wb_en_s, taken_s;
    logic             use_rd_s, use_rs1_s, use_rs2_s;
    logic [WIDTH-1:0] wb_data_s, target_s;

    // Decode and execute the latched instruction.
    always_comb begin
        ill_s     = 1'b0;
        brk_s     = 1'b0;
        wb_en_s   = 1'b0;
        taken_s   = 1'b0;
        use_rd_s  = 1'b0;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        wb_data_s = '0;
        target_s  = pc4_s;
        case (opcode_s)
            7'b0110111: begin  // LUI
                wb_en_s = 1'b1; use_rd_s = 1'b1; wb_data_s = imm_u_s;
            end
            7'b0010111: begin  // AUIPC
                wb_en_s = 1'b1; use_rd_s = 1'b1; wb_data_s = pc_r + imm_u_s;
            end
            7'b1101111: begin  // JAL
                wb_en_s = 1'b1; use_rd_s = 1'b1; wb_data_s = pc4_s;
                taken_s = 1'b1; target_s = pc_r + imm_j_s;
            end
            7'b1100111: begin  // JALR: target uses the pre-write rs1
                wb_en_s = 1'b1; use_rd_s = 1'b1; use_rs1_s = 1'b1; wb_data_s = pc4_s;
                taken_s = 1'b1; target_s = {jalr_sum_s[WIDTH-1:1], 1'b0};
                ill_s   = (f3_s != 3'b000);
            end
            7'b1100011: begin  // BRANCH
                use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                target_s  = pc_r + imm_b_s;
                case (f3_s)
                    3'b000:  taken_s = (rs1_val_s == rs2_val_s);
                    3'b001:  taken_s = (rs1_val_s != rs2_val_s);
                    3'b100:  taken_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
                    3'b101:  taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
                    3'b110:  taken_s = (rs1_val_s <  rs2_val_s);
                    3'b111:  taken_s = (rs1_val_s >= rs2_val_s);
                    default: ill_s   = 1'b1;
                endcase
            end
            7'b0010011: begin  // OP-IMM; shifts must carry a valid funct7 pattern
                wb_en_s = 1'b1; use_rd_s = 1'b1; use_rs1_s = 1'b1;
                wb_data_s = alu(f3_s, (f3_s == 3'b101) && inst_r[30], rs1_val_s, imm_i_s);
                case (f3_s)
                    3'b001:  ill_s = (inst_r[31:26] != 6'b000000) || ((WIDTH == 32) && inst_r[25]);
                    3'b101:  ill_s = ((inst_r[31:26] != 6'b000000) && (inst_r[31:26] != 6'b010000))
                                     || ((WIDTH == 32) && inst_r[25]);
                    default: ill_s = 1'b0;
                endcase
            end
            7'b0110011: begin  // OP; funct7 0100000 only for SUB and SRA
                wb_en_s = 1'b1; use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                wb_data_s = alu(f3_s, inst_r[30], rs1_val_s, rs2_val_s);
                ill_s = !((f7_s == 7'b0000000) ||
                          ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
            end
            7'b1110011: begin  // SYSTEM: only EBREAK is supported
                if (inst_r == 32'h0010_0073) begin
                    brk_s = 1'b1;
                end else begin
                    ill_s = 1'b1;
                end
            end
            default: ill_s = 1'b1;
        endcase
    end

    logic rve_bad_s, fault_s, stop_s, retire_s;

    assign rve_bad_s = RVE_EN && ((use_rd_s && rd_s[4]) || (use_rs1_s && rs1_idx_s[4]) ||
                                  (use_rs2_s && rs2_idx_s[4]));
    // A taken redirect whose target is not word aligned is a fault.
    assign fault_s   = ill_s || rve_bad_s || (taken_s && target_s[1]);
    assign stop_s    = fault_s || brk_s;
    assign retire_s  = (state_r == EXEC) && !stop_s;

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= FETCH;
            pc_r        <= PC_START;
            inst_r      <= 32'h0000_0000;
            req_valid_r <= 1'b1;
            commit_r    <= 1'b0;
            halt_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            commit_r <= 1'b0;
            case (state_r)
                FETCH: begin
                    if (ifu_req_ready) begin
                        state_r     <= WAIT;
                        req_valid_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (ifu_rsp_valid) begin
                        inst_r  <= ifu_rsp_inst;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    if (stop_s) begin
                        state_r   <= HALT;
                        halt_r    <= 1'b1;
                        illegal_r <= fault_s;
                    end else begin
                        pc_r        <= taken_s ? target_s : pc4_s;
                        commit_r    <= 1'b1;
                        req_valid_r <= 1'b1;
                        state_r     <= FETCH;
                    end
                end
                HALT:    state_r <= HALT;
                default: state_r <= FETCH;
            endcase
        end
    end

    // Register file write port; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_N; i++) begin
                rf_r[i] <= '0;
            end
        end else if (retire_s && wb_en_s && (rd_s != 5'd0)) begin
            rf_r[rd_s[RF_AW-1:0]] <= wb_data_s;
        end
    end

    assign ifu_req_valid = req_valid_r;
    assign ifu_addr      = pc_r;
    assign pc            = pc_r;
    assign commit        = commit_r;
    assign halt          = halt_r;
    assign illegal       = illegal_r;

endmodule

// File: tb/tb_gpc_mc.sv
// Directed bench for gpc_mc: a table of instructions executed back to back
// from reset, followed by hand-written reset, stall and halt sequences.
module tb_gpc_mc;

    localparam logic [31:0] PC0 = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic [31:0] pc;
    logic        commit;
    logic        halt;
    logic        illegal;

    int n_chk  = 0;
    int n_fail = 0;

    gpc_mc dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr     (ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_inst (ifu_rsp_inst),
        .pc           (pc),
        .commit       (commit),
        .halt         (halt),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        commit;
        logic        halt;
        logic        ill;
        int          rd;    // register to inspect, -1 for none
        logic [31:0] val;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; leaves the core in FETCH.
    task automatic do_reset();
        rst           = 1'b1;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'h0000_0000;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One instruction: handshake, response one cycle later, EXEC, then return
    // #1 into the cycle after EXEC. A junk response is offered during the
    // handshake cycle and must be ignored.
    task automatic do_inst(input logic [31:0] inst);
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h0000_0000;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = inst;
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'h0000_0000;
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{32'h0050_0093, 32'h8000_0004, 1'b1, 1'b0, 1'b0, 1,  32'h0000_0005}; // ADDI x1,x0,5
        vecs[1]  = '{32'hFFF0_0093, 32'h8000_0008, 1'b1, 1'b0, 1'b0, 1,  32'hFFFF_FFFF}; // ADDI x1,x0,-1
        vecs[2]  = '{32'h0010_3133, 32'h8000_000C, 1'b1, 1'b0, 1'b0, 2,  32'h0000_0001}; // SLTU x2,x0,x1
        vecs[3]  = '{32'h0010_21B3, 32'h8000_0010, 1'b1, 1'b0, 1'b0, 3,  32'h0000_0000}; // SLT x3,x0,x1
        vecs[4]  = '{32'h0000_0463, 32'h8000_0018, 1'b1, 1'b0, 1'b0, -1, 32'h0000_0000}; // BEQ x0,x0,+8
        vecs[5]  = '{32'h0000_1463, 32'h8000_001C, 1'b1, 1'b0, 1'b0, -1, 32'h0000_0000}; // BNE x0,x0,+8
        vecs[6]  = '{32'h41F0_D213, 32'h8000_0020, 1'b1, 1'b0, 1'b0, 4,  32'hFFFF_FFFF}; // SRAI x4,x1,31
        vecs[7]  = '{32'h1234_52B7, 32'h8000_0024, 1'b1, 1'b0, 1'b0, 5,  32'h1234_5000}; // LUI x5
        vecs[8]  = '{32'h0000_1317, 32'h8000_0028, 1'b1, 1'b0, 1'b0, 6,  32'h8000_1024}; // AUIPC x6,1
        vecs[9]  = '{32'h4012_83B3, 32'h8000_002C, 1'b1, 1'b0, 1'b0, 7,  32'h1234_5001}; // SUB x7,x5,x1
        vecs[10] = '{32'h0070_0013, 32'h8000_0030, 1'b1, 1'b0, 1'b0, 0,  32'h0000_0000}; // ADDI x0,x0,7
        vecs[11] = '{32'h0080_04EF, 32'h8000_0038, 1'b1, 1'b0, 1'b0, 9,  32'h8000_0034}; // JAL x9,+8
        vecs[12] = '{32'h0000_0517, 32'h8000_003C, 1'b1, 1'b0, 1'b0, 10, 32'h8000_0038}; // AUIPC x10,0
        vecs[13] = '{32'h00D5_0567, 32'h8000_0044, 1'b1, 1'b0, 1'b0, 10, 32'h8000_0040}; // JALR x10,x10,13
        vecs[14] = '{32'h0000_A593, 32'h8000_0048, 1'b1, 1'b0, 1'b0, 11, 32'h0000_0001}; // SLTI x11,x1,0
        vecs[15] = '{32'h0000_C663, 32'h8000_0054, 1'b1, 1'b0, 1'b0, -1, 32'h0000_0000}; // BLT x1,x0,+12
        vecs[16] = '{32'h0000_E663, 32'h8000_0058, 1'b1, 1'b0, 1'b0, -1, 32'h0000_0000}; // BLTU x1,x0,+12
        vecs[17] = '{32'h0070_D633, 32'h8000_005C, 1'b1, 1'b0, 1'b0, 12, 32'h7FFF_FFFF}; // SRL x12,x1,x7
        vecs[18] = '{32'h0060_00EF, 32'h8000_005C, 1'b0, 1'b1, 1'b1, 1,  32'hFFFF_FFFF}; // JAL x1,+6

        rst           = 1'b1;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'h0000_0000;
        #1;
        chk("rst pc", pc, PC0);
        chk("rst halt", {31'd0, halt}, 32'd0);
        @(posedge clk); #1;
        do_reset();

        // Reset state and first request.
        chk("post-rst req_valid", {31'd0, ifu_req_valid}, 32'd1);
        chk("post-rst addr", ifu_addr, PC0);
        chk("post-rst commit", {31'd0, commit}, 32'd0);
        chk("post-rst illegal", {31'd0, illegal}, 32'd0);

        // Stalled request with a stray response that must be ignored.
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h0070_0093;  // ADDI x1,x0,7
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d req_valid", i), {31'd0, ifu_req_valid}, 32'd1);
            chk($sformatf("stall%0d addr", i), ifu_addr, PC0);
            chk($sformatf("stall%0d commit", i), {31'd0, commit}, 32'd0);
        end
        ifu_rsp_valid = 1'b0;
        chk("stall x1", dut.rf_r[1], 32'd0);

        for (int i = 0; i < 19; i++) begin
            do_inst(vecs[i].inst);
            chk($sformatf("v%0d pc", i), pc, vecs[i].pc);
            chk($sformatf("v%0d commit", i), {31'd0, commit}, {31'd0, vecs[i].commit});
            chk($sformatf("v%0d halt", i), {31'd0, halt}, {31'd0, vecs[i].halt});
            chk($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
            chk($sformatf("v%0d req_valid", i), {31'd0, ifu_req_valid}, {31'd0, !vecs[i].halt});
            if (vecs[i].rd >= 0) begin
                chk($sformatf("v%0d x%0d", i, vecs[i].rd), dut.rf_r[vecs[i].rd], vecs[i].val);
            end
            if (commit === 1'b1) begin
                @(posedge clk); #1;
                chk($sformatf("v%0d commit pulse", i), {31'd0, commit}, 32'd0);
            end
        end

        // Halted core stays put even if the fetch side offers a handshake.
        ifu_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("halt hold pc", pc, 32'h8000_005C);
        chk("halt hold req_valid", {31'd0, ifu_req_valid}, 32'd0);
        chk("halt hold halt", {31'd0, halt}, 32'd1);
        ifu_req_ready = 1'b0;

        // Reset acts immediately, then an all-zero word is illegal.
        rst = 1'b1;
        #1;
        chk("async rst halt", {31'd0, halt}, 32'd0);
        chk("async rst illegal", {31'd0, illegal}, 32'd0);
        chk("async rst pc", pc, PC0);
        chk("async rst req_valid", {31'd0, ifu_req_valid}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_inst(32'h0000_0000);
        chk("zero halt", {31'd0, halt}, 32'd1);
        chk("zero illegal", {31'd0, illegal}, 32'd1);
        chk("zero pc", pc, PC0);
        chk("zero commit", {31'd0, commit}, 32'd0);

        // EBREAK halts without the illegal flag.
        do_reset();
        do_inst(32'h0010_0073);
        chk("ebreak halt", {31'd0, halt}, 32'd1);
        chk("ebreak illegal", {31'd0, illegal}, 32'd0);
        chk("ebreak commit", {31'd0, commit}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("ebreak%0d req_valid", i), {31'd0, ifu_req_valid}, 32'd0);
        end

        // Reset during WAIT, then a stale response after reset.
        do_reset();
        ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        chk("wait req_valid", {31'd0, ifu_req_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h0050_0093;  // ADDI x1,x0,5
        repeat (2) @(posedge clk);
        #1;
        ifu_rsp_valid = 1'b0;
        chk("stale req_valid", {31'd0, ifu_req_valid}, 32'd1);
        chk("stale addr", ifu_addr, PC0);
        chk("stale commit", {31'd0, commit}, 32'd0);
        chk("stale x1", dut.rf_r[1], 32'd0);

        do_inst(32'h0010_0813);  // ADDI x16,x0,1
`ifdef GPC_MC_RVE_EN
        chk("x16 illegal", {31'd0, illegal}, 32'd1);
        chk("x16 halt", {31'd0, halt}, 32'd1);
        chk("x16 pc", pc, PC0);
`else
        chk("x16 commit", {31'd0, commit}, 32'd1);
        chk("x16 pc", pc, PC0 + 32'd4);
        chk("x16 value", dut.rf_r[16], 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gpc_mc.md
GPC_MC -- requirements
Module: gpc_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/register width (32 or 64).
REQ-002 SHALL have parameter PC_START, default 32'h8000_0000, PC value after reset.
REQ-003 SHALL have parameter NR_REGS, default 32, register count; ADDR_WIDTH, default 5, log2(NR_REGS).
REQ-004 SHALL have ports: clk  in  1  the only clock; rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: ifu_req_valid  out  1  fetch request; ifu_req_ready  in  1  request accepted; ifu_addr  out  WIDTH  fetch address.
REQ-006 SHALL have ports: ifu_rsp_valid  in  1  instruction valid; ifu_rsp_inst  in  32  instruction word.
REQ-007 SHALL have ports: pc  out  WIDTH  current PC; commit  out  1  retire pulse; halt  out  1  core stopped; illegal  out  1  halt cause was illegal/misaligned.

Function
REQ-008 SHALL be a multi-cycle RV32I-subset core with FSM states FETCH, WAIT, EXEC, HALT.
REQ-009 FETCH: ifu_req_valid=1, ifu_addr=pc; on ifu_req_valid&ifu_req_ready -> WAIT; addr held stable while unaccepted.
REQ-010 WAIT: on ifu_rsp_valid latch ifu_rsp_inst -> EXEC; ifu_rsp_valid ignored in every other state, including the handshake cycle.
REQ-011 EXEC: one cycle; decode, execute, write rd, update pc -> FETCH; minimum 3 cycles per instruction.
REQ-012 Supported: LUI, AUIPC, JAL, JALR, all six BRANCH, OP-IMM (ADDI..SRAI), OP (ADD..AND incl. SUB/SRA), EBREAK.
REQ-013 Immediates SHALL be sign-extended to WIDTH; arithmetic wraps modulo 2^WIDTH; shift amount = low log2(WIDTH) bits of rs2/imm.
REQ-014 SLT/SLTI signed, SLTU/SLTIU unsigned compares, result 0 or 1 zero-extended.
REQ-015 x0 SHALL read 0; writes to x0 discarded.
REQ-016 JAL/JALR write pc+4 to rd; JALR target = (rs1+imm) with bit0 cleared; rd==rs1 uses old rs1.
REQ-017 Not-taken branch and non-jump instructions: pc <= pc+4.
REQ-018 Taken branch/jump target with bit1 set: no writeback, pc unchanged, halt=1, illegal=1 -> HALT.
REQ-019 Unsupported opcode/funct: no writeback, pc unchanged, halt=1, illegal=1 -> HALT.
REQ-020 EBREAK: no writeback, pc unchanged, halt=1, illegal=0 -> HALT.
REQ-021 HALT SHALL be terminal until rst; ifu_req_valid=0, no register writes.
REQ-022 commit SHALL pulse 1 cycle in the cycle after EXEC for retired instructions only (not illegal, not EBREAK); pc already shows new value.

Reset
REQ-023 rst asserted SHALL immediately force state FETCH, pc=PC_START, all registers 0, commit=0, halt=0, illegal=0.
REQ-024 Reset mid-transaction abandons the outstanding fetch; a late ifu_rsp_valid after reset is ignored (REQ-010).
REQ-025 First ifu_req_valid SHALL assert in the first clk edge's cycle after rst deasserts with ifu_addr=PC_START.

Configuration
REQ-026 Macro GPC_MC_RVE_EN defined: register file has 16 entries; any used rd/rs1/rs2 field with bit4 set is illegal per REQ-019.
REQ-027 GPC_MC_RVE_EN undefined: NR_REGS registers, all 5-bit fields legal.

Verification
REQ-028 Reset, ready=1, rsp after 1 cycle: ADDI x1,x0,5 at 0x8000_0000 -> x1=5, commit pulse, pc=0x8000_0004, 3 cycles/instr.
REQ-029 ifu_req_ready low 4 cycles -> ifu_req_valid and ifu_addr stable, no commit until accepted.
REQ-030 x1=-1: SLTU x2,x0,x1 -> x2=1; SLT x3,x0,x1 -> x3=0; SRAI x4,x1,31 -> x4=0xFFFF_FFFF.
REQ-031 BEQ x0,x0,+8 at 0x8000_0010 -> pc=0x8000_0018; BNE x0,x0,+8 -> pc+4; JAL x1,+6 -> halt=1, illegal=1, x1 unchanged.
REQ-032 Inst 0x0000_0000 -> halt=1, illegal=1; EBREAK -> halt=1, illegal=0, ifu_req_valid stays 0.
REQ-033 rst pulse during WAIT, then stale rsp_valid -> ignored; fetch restarts at PC_START; with GPC_MC_RVE_EN, ADDI x16,x0,1 -> illegal=1.
